// File: rtl/pc_target_table_if.sv
// Load/lookup bus for pc_target_table.
// master = fetch-side requester, slave = the table.
interface pc_target_table_if #(
  parameter int D = 12,
  parameter int A = 4
);
  logic         wr_valid;
  logic         wr_ready;
  logic [A-1:0] wr_addr;
  logic [D-1:0] wr_data;
  logic         wr_rel;
  logic         rd_valid;
  logic [A-1:0] rd_addr;
  logic [D-1:0] pc;
  logic [D-1:0] target;
  logic         target_valid;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_rel, rd_valid, rd_addr, pc,
    input  wr_ready, target, target_valid
  );
  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_rel, rd_valid, rd_addr, pc,
    output wr_ready, target, target_valid
  );
endinterface

// File: rtl/pc_target_table.sv
// pc_target_table: run-time writable 2**A x D branch/jump target table.
// Self-clears after reset (2**A cycle sweep), 1-cycle registered lookup,
// write-first on same-index load+lookup.
// Optional macro PC_REL_MODE_EN: per-entry rel bit; relative entries
// return (pc + value) mod 2**D. Without it, pc and wr_rel are ignored.
module pc_target_table #(
  parameter int D = 12,
  parameter int A = 4
) (
  input  logic                  Clk,
  input  logic                  Reset,
  output logic                  busy,
  pc_target_table_if.slave      bus
);
  localparam int DEPTH = 2**A;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t       r_state;
  logic [A-1:0] r_idx;
  logic         r_busy;
  logic         r_wr_ready;
  logic [D-1:0] r_val [DEPTH];
  logic [D-1:0] r_target;
  logic         r_target_valid;

  logic         w_wr_fire;
  logic         w_hit;
  logic [D-1:0] w_val;
  logic [D-1:0] w_target;

  // wr_ready is exactly "state is READY", so a fire only happens in READY
  assign w_wr_fire = bus.wr_valid && r_wr_ready;
  assign w_hit     = w_wr_fire && (bus.wr_addr == bus.rd_addr);
  assign w_val     = w_hit ? bus.wr_data : r_val[bus.rd_addr];

`ifdef PC_REL_MODE_EN
  logic r_rel [DEPTH];
  logic w_rel;

  assign w_rel    = w_hit ? bus.wr_rel : r_rel[bus.rd_addr];
  // D-bit add, carry dropped: negative offsets are plain two's complement
  assign w_target = w_rel ? (bus.pc + w_val) : w_val;

  // rel bits follow the same clear-sweep / load path as the values
  always_ff @(posedge Clk) begin
    if (Reset) begin
      if (r_state == S_CLEAR)
        r_rel[r_idx] <= 1'b0;
      else if (w_wr_fire)
        r_rel[bus.wr_addr] <= bus.wr_rel;
    end
  end
`else
  logic w_unused_ok;
  assign w_unused_ok = ^{bus.wr_rel, bus.pc};
  assign w_target    = w_val;
`endif

  // FSM: clear sweep over every index, then READY until the next reset
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_state    <= S_CLEAR;
      r_idx      <= '0;
      r_busy     <= 1'b1;
      r_wr_ready <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_idx <= r_idx + 1'b1;
          if (r_idx == '1) begin
            r_state    <= S_READY;
            r_busy     <= 1'b0;
            r_wr_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= S_READY;
          r_busy     <= 1'b0;
          r_wr_ready <= 1'b1;
        end
      endcase
    end
  end

  // table storage: sweep writes zero, READY accepts loads; no write in reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      if (r_state == S_CLEAR)
        r_val[r_idx] <= '0;
      else if (w_wr_fire)
        r_val[bus.wr_addr] <= bus.wr_data;
    end
  end

  // registered lookup; target holds when no lookup is taken
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      r_target       <= '0;
      r_target_valid <= 1'b0;
    end else if (bus.rd_valid && r_state == S_READY) begin
      r_target       <= w_target;
      r_target_valid <= 1'b1;
    end else begin
      r_target_valid <= 1'b0;
    end
  end

  assign busy             = r_busy;
  assign bus.wr_ready     = r_wr_ready;
  assign bus.target       = r_target;
  assign bus.target_valid = r_target_valid;
endmodule

// File: tb/tb_pc_target_table.sv
// Scoreboard bench for pc_target_table (D=12, A=4).
// Lookups push the model's expected target; a negedge monitor pops and
// compares every target_valid pulse.
module tb_pc_target_table;
  localparam int D = 12;
  localparam int A = 4;
  localparam int DEPTH = 2**A;

  logic Clk = 1'b0;
  logic Reset;
  logic busy;

  pc_target_table_if #(.D(D), .A(A)) bus ();

  pc_target_table #(.D(D), .A(A)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .busy  (busy),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  logic [D-1:0] m_val [DEPTH];
  logic         m_rel [DEPTH];
  logic [D-1:0] sb_q [$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // every target_valid pulse must match the oldest outstanding lookup
  always @(negedge Clk) begin
    if (bus.target_valid === 1'b1) begin
      if (sb_q.size() == 0)
        chk("unexpected_target_valid", 32'(bus.target_valid), 32'd0);
      else
        chk("target", 32'(bus.target), 32'(sb_q.pop_front()));
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.wr_rel   = 1'b0;
    bus.rd_valid = 1'b0;
    bus.rd_addr  = '0;
    bus.pc       = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_val[i] = '0;
      m_rel[i] = 1'b0;
    end
  endtask

  // one READY-phase cycle: optional load and optional lookup, write-first
  task automatic cyc(input logic wv, input int wa, input int wd, input logic wr,
                     input logic rv, input int ra, input int pcv);
    logic [D-1:0] e;
    bus.wr_valid = wv;
    bus.wr_addr  = A'(wa);
    bus.wr_data  = D'(wd);
    bus.wr_rel   = wr;
    bus.rd_valid = rv;
    bus.rd_addr  = A'(ra);
    bus.pc       = D'(pcv);
    if (wv) begin
      m_val[wa] = D'(wd);
      m_rel[wa] = wr;
    end
    if (rv) begin
`ifdef PC_REL_MODE_EN
      e = m_rel[ra] ? D'(m_val[ra] + D'(pcv)) : m_val[ra];
`else
      e = m_val[ra];
`endif
      sb_q.push_back(e);
    end
    tick();
    idle();
  endtask

  // release reset and count posedges until busy drops (bounded)
  task automatic sweep(input string tag, input logic rd_during);
    int n;
    Reset = 1'b1;
    bus.rd_valid = rd_during;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy === 1'b1 && n < 40);
    bus.rd_valid = 1'b0;
    chk(tag, 32'(n), 32'd16);
    chk({tag, "_wr_ready"}, 32'(bus.wr_ready), 32'd1);
  endtask

  task automatic pulse_reset();
    Reset = 1'b0;
    tick();
    model_clear();
  endtask

  initial begin
    idle();
    model_clear();
    Reset = 1'b0;
    tick();
    tick();
    // reset state
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_wr_ready", 32'(bus.wr_ready), 32'd0);
    chk("rst_target", 32'(bus.target), 32'd0);
    chk("rst_target_valid", 32'(bus.target_valid), 32'd0);

    // 1: sweep with lookups requested throughout -> no pulses, then all zero
    sweep("sweep_len", 1'b1);
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 0, 0, 1, i, 0);

    // 2: loads then back-to-back reads
    cyc(1, 1, 37, 0, 0, 0, 0);
    chk("wr_ready_ready", 32'(bus.wr_ready), 32'd1);
    cyc(1, 2, 64, 0, 0, 0, 0);
    cyc(1, 3, 72, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 2, 0);
    cyc(0, 0, 0, 0, 1, 3, 0);

    // 3: same-cycle load and lookup of one index, plus a different-index pair
    cyc(1, 4, 79, 0, 1, 4, 0);
    cyc(1, 8, 123, 0, 1, 1, 0);
    cyc(0, 0, 0, 0, 1, 8, 0);

    // 4: relative entries (wrap), absolute in default build
    cyc(1, 5, 'hFFB, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 5, 'h004);
    cyc(1, 6, 'h014, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 6, 'hFF0);
    cyc(1, 9, 'h100, 0, 1, 9, 'h0AB);
    tick();
    chk("target_hold", 32'(bus.target), 32'h100);

    // 5: reset mid-sweep restarts a full sweep and wipes loads
    cyc(1, 7, 99, 0, 0, 0, 0);
    pulse_reset();
    Reset = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    chk("midsweep_busy", 32'(busy), 32'd1);
    pulse_reset();
    chk("rst2_target_valid", 32'(bus.target_valid), 32'd0);
    sweep("resweep_len", 1'b0);
    cyc(0, 0, 0, 0, 1, 7, 0);
    cyc(0, 0, 0, 0, 1, 1, 0);

    // 6: load held across the sweep lands on the first READY edge
    pulse_reset();
    bus.wr_valid = 1'b1;
    bus.wr_addr  = '0;
    bus.wr_data  = D'(16);
    sweep("held_sweep_len", 1'b0);
    cyc(1, 0, 16, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);

    tick();
    tick();
    chk("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
